// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, write-data select codes and stack operation decode.
package cpu_pkg;

    localparam logic [3:0] OP_PUSH  = 4'b1110;
    localparam logic [3:0] OP_POP   = 4'b1111;
    localparam logic [1:0] WD_STACK = 2'b10;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_REPLACE,
        ST_OVF,
        ST_UNF
    } stack_op_e;

    // Push+pop on an empty stack degrades to a plain push, never an underflow.
    function automatic stack_op_e decode_op(input logic push, input logic pop,
                                            input logic full, input logic empty);
        if (push && pop) return empty ? ST_PUSH : ST_REPLACE;
        if (push)        return full  ? ST_OVF  : ST_PUSH;
        if (pop)         return empty ? ST_UNF  : ST_POP;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the stack pointer alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack for PUSH/POP: pointer, error flags and registered pop data around stack_mem.
module stack_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 8,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam int AW = SP_W - 1;

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    stack_op_e         op;
    logic              mem_we;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;
    logic [DATA_W-1:0] top_data;

    assign full    = (sp_q == SP_W'(DEPTH));
    assign empty   = (sp_q == '0);
    // Wraps harmlessly when empty: the result is only used on legal pops/replaces.
    assign top_idx = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        op         = decode_op(push, pop, full, empty);
        sp_d       = sp_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        wr_idx     = sp_q[AW-1:0];
        ovf_d      = ovf_q & ~clr_err;
        unf_d      = unf_q & ~clr_err;
        case (op)
            ST_PUSH: begin
                mem_we = 1'b1;
                sp_d   = sp_q + SP_W'(1);
            end
            ST_POP: begin
                rd_data_d  = top_data;
                rd_valid_d = 1'b1;
                sp_d       = sp_q - SP_W'(1);
            end
            ST_REPLACE: begin
                mem_we     = 1'b1;
                wr_idx     = top_idx;
                rd_data_d  = top_data;
                rd_valid_d = 1'b1;
            end
            ST_OVF:  ovf_d = 1'b1;
            ST_UNF:  unf_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (wr_data),
        .raddr (top_idx),
        .rdata (top_data)
    );

    assign sp       = sp_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;

endmodule
